// File: rtl/flash_burst_rd_pkg.sv
// flash_burst_rd_pkg: shared APB widths, flash window defaults and burst reader state encoding
package flash_burst_rd_pkg;

    localparam int P_ADDR_W = 32;
    localparam int P_DATA_W = 32;

    localparam logic [P_ADDR_W-1:0] FLASH_BASE_DEF = 32'h3000_0000;
    localparam logic [P_ADDR_W-1:0] FLASH_END_DEF  = 32'h3fff_ffff;

    localparam logic [2:0] PPROT_INSTR = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic in_window(
        input logic [P_ADDR_W-1:0] addr,
        input logic [P_ADDR_W-1:0] lo,
        input logic [P_ADDR_W-1:0] hi
    );
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/flash_burst_rd_addr_gen.sv
// flash_burst_addr_gen: next beat address; wrapping bursts for len 1/3/7 when FLASH_BURST_WRAP_EN is defined
module flash_burst_addr_gen #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    len,
    output logic [AW-1:0] next
);

    logic [AW-1:0] inc;

    assign inc = addr + AW'(4);

`ifdef FLASH_BURST_WRAP_EN
    logic          wrap;
    logic [AW-1:0] mask;

    assign wrap = (len == 3'd1) || (len == 3'd3) || (len == 3'd7);
    // byte offset mask of the (len+1)*4 block the burst wraps inside
    assign mask = {{(AW-5){1'b0}}, len, 2'b11};
    assign next = wrap ? ((addr & ~mask) | (inc & mask)) : inc;
`else
    logic unused_len;

    assign unused_len = ^len;
    assign next       = inc;
`endif

endmodule

// File: rtl/flash_burst_rd.sv
// flash_burst_rd: burst word reader turning req/rsp handshakes into APB reads toward the SPI flash bridge
// Optional wrapping bursts with FLASH_BURST_WRAP_EN (see flash_burst_addr_gen).
module flash_burst_rd
    import flash_burst_rd_pkg::*;
#(
    parameter logic [P_ADDR_W-1:0] FLASH_BASE = FLASH_BASE_DEF,
    parameter logic [P_ADDR_W-1:0] FLASH_END  = FLASH_END_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [P_ADDR_W-1:0]   req_addr,
    input  logic [2:0]            req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [P_DATA_W-1:0]   rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic [P_ADDR_W-1:0]   out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic                  out_pwrite,
    output logic [2:0]            out_pprot,
    output logic [P_DATA_W/8-1:0] out_pstrb,
    output logic [P_DATA_W-1:0]   out_pwdata,
    input  logic                  out_pready,
    input  logic [P_DATA_W-1:0]   out_prdata,
    input  logic                  out_pslverr
);

    state_t                state_q, state_d;
    logic [P_ADDR_W-1:0]   addr_q, addr_nxt, req_aligned;
    logic [2:0]            len_q, cnt_q;
    logic [P_DATA_W-1:0]   data_q;
    logic                  last_q, err_q;
    logic                  accept, in_rng, beat_done, advance;
    logic                  unused_lsb;

    assign unused_lsb  = ^req_addr[1:0];
    assign req_aligned = {req_addr[P_ADDR_W-1:2], 2'b00};
    assign in_rng      = in_window(req_aligned, FLASH_BASE, FLASH_END);
    assign accept      = req_valid && req_ready;
    assign beat_done   = (state_q == ACCESS) && out_pready;
    assign advance     = (state_q == RESP) && rsp_ready && !last_q;

    flash_burst_addr_gen #(.AW(P_ADDR_W)) u_addr_gen (
        .addr (addr_q),
        .len  (len_q),
        .next (addr_nxt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        out_psel    = 1'b0;
        out_penable = 1'b0;
        rsp_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = in_rng ? SETUP : RESP;
            end
            SETUP: begin
                out_psel = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                out_psel    = 1'b1;
                out_penable = 1'b1;
                if (out_pready)
                    state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = last_q ? IDLE : SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // out-of-window requests become a single error beat without touching APB
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_aligned;
                len_q  <= req_len;
                cnt_q  <= '0;
                data_q <= '0;
                last_q <= !in_rng;
                err_q  <= !in_rng;
            end
            if (beat_done) begin
                data_q <= out_prdata;
                err_q  <= out_pslverr;
                last_q <= out_pslverr || (cnt_q == len_q);
            end
            if (advance) begin
                cnt_q  <= cnt_q + 3'd1;
                addr_q <= addr_nxt;
            end
        end
    end

    assign rsp_data   = data_q;
    assign rsp_last   = last_q;
    assign rsp_err    = err_q;
    assign out_paddr  = addr_q;
    assign out_pwrite = 1'b0;
    assign out_pprot  = PPROT_INSTR;
    assign out_pstrb  = '0;
    assign out_pwdata = '0;

endmodule

// File: tb/tb_flash_burst_rd.sv
// tb_flash_burst_rd: directed and randomized bursts against a queue-based burst model with an APB slave
module tb_flash_burst_rd;
    import flash_burst_rd_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last, rsp_err;
    logic [31:0] out_paddr;
    logic        out_psel, out_penable, out_pwrite;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;
    logic [31:0] out_pwdata;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    int compared = 0;
    int mismatched = 0;

    int          ws = 0;
    int          wcnt = 0;
    logic [31:0] err_addr = 32'h1;
    logic [31:0] apb_q[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_a = '0;

    flash_burst_rd dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pwrite(out_pwrite), .out_pprot(out_pprot), .out_pstrb(out_pstrb),
        .out_pwdata(out_pwdata), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] l, input int i);
        logic [31:0] blk, lo;
`ifdef FLASH_BURST_WRAP_EN
        if (l == 3'd1 || l == 3'd3 || l == 3'd7) begin
            blk = (l + 1) * 4;
            lo  = a - (a % blk);
            return lo + ((a - lo + 4 * i) % blk);
        end
`endif
        blk = 0;
        lo  = 0;
        return a + 4 * i + blk + lo;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    assign out_pready  = out_psel && out_penable && (wcnt >= ws);
    assign out_prdata  = data_of(out_paddr);
    assign out_pslverr = out_pready && (out_paddr == err_addr);

    always @(posedge clk) wcnt <= (out_psel && out_penable && !out_pready) ? wcnt + 1 : 0;

    always @(negedge clk) begin
        if (!resetn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("apb_hold_sel", {out_psel, out_penable}, 2'b11);
                chk("apb_hold_addr", out_paddr, hold_a);
            end
            if (out_psel && !out_penable) apb_q.push_back(out_paddr);
            if (out_psel)
                chk("apb_const", {out_pwrite, out_pstrb, out_pwdata, out_pprot}, {1'b0, 4'h0, 32'h0, 3'b100});
            hold_v = out_psel && !(out_penable && out_pready);
            hold_a = out_paddr;
        end
    end

    task automatic accept_req(input logic [31:0] a, input logic [2:0] l);
        logic rdy;
        int   n;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        n = 0;
        do begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        chk("req_accept", rdy, 1'b1);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_len   = 3'($urandom);
    endtask

    task automatic do_burst(input logic [31:0] a, input logic [2:0] l, input int wsv,
                            input int stall_beat, input int stall_n, input logic [31:0] eaddr);
        logic [31:0] exp_a[$], exp_d[$];
        logic        exp_e[$], exp_l[$];
        logic [31:0] aa, ad;
        logic        in_rng;
        int          n;
        aa     = {a[31:2], 2'b00};
        in_rng = (aa >= 32'h3000_0000) && (aa <= 32'h3fff_ffff);
        if (!in_rng) begin
            exp_d.push_back(0);
            exp_e.push_back(1'b1);
            exp_l.push_back(1'b1);
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                ad = beat_addr(aa, l, i);
                exp_a.push_back(ad);
                exp_d.push_back(data_of(ad));
                exp_e.push_back(ad == eaddr);
                exp_l.push_back(i == int'(l) || ad == eaddr);
                if (ad == eaddr) break;
            end
        end
        ws       = wsv;
        err_addr = eaddr;
        apb_q.delete();
        accept_req(a, l);
        for (int b = 0; b < exp_d.size(); b++) begin
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("rsp_valid", rsp_valid, 1'b1);
            if (b == 0) chk("first_latency", n, in_rng ? 2 + wsv : 0);
            chk("rsp_data", rsp_data, exp_d[b]);
            chk("rsp_err", rsp_err, exp_e[b]);
            chk("rsp_last", rsp_last, exp_l[b]);
            for (int s = 0; b == stall_beat && s < stall_n; s++) begin
                @(posedge clk);
                #1;
                chk("stall_psel", out_psel, 1'b0);
                chk("stall_valid", rsp_valid, 1'b1);
                chk("stall_data", rsp_data, exp_d[b]);
                chk("stall_last", rsp_last, exp_l[b]);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
        chk("idle_after", req_ready, 1'b1);
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("apb_count", apb_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < apb_q.size(); i++)
            chk("apb_addr", apb_q[i], exp_a[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, ea;
        logic [2:0]  l;
        int          r, n;
        #1;
        chk("rst_sel", {out_psel, out_penable, rsp_valid}, 3'b000);
        chk("rst_paddr", out_paddr, 0);
        chk("rst_rsp", {rsp_data, rsp_last, rsp_err}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1'b1);

        do_burst(32'h3000_0010, 3'd0, 0, -1, 0, 32'h1);
        do_burst(32'h3000_0000, 3'd3, 2, 1, 4, 32'h1);
        do_burst(32'h2000_0000, 3'd7, 0, -1, 0, 32'h1);
        do_burst(32'h3000_0000, 3'd7, 0, -1, 0, 32'h3000_0008);
        do_burst(32'h3000_0018, 3'd7, 1, -1, 0, 32'h1);
        do_burst(32'h2fff_fffc, 3'd1, 0, -1, 0, 32'h1);
        do_burst(32'h4000_0000, 3'd0, 0, -1, 0, 32'h1);
        do_burst(32'h3fff_fffc, 3'd3, 0, 0, 2, 32'h1);
        do_burst(32'h3fff_ffff, 3'd0, 1, -1, 0, 32'h1);
        do_burst(32'h3000_0003, 3'd1, 0, -1, 0, 32'h3000_0000);

        ws       = 3;
        err_addr = 32'h1;
        accept_req(32'h3000_0000, 3'd3);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n = 0;
        while (!(out_psel && out_penable) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_rst_access", {out_psel, out_penable}, 2'b11);
        resetn = 1'b0;
        #1;
        chk("midrst_sel", {out_psel, out_penable, rsp_valid}, 3'b000);
        chk("midrst_paddr", out_paddr, 0);
        chk("midrst_rsp", {rsp_data, rsp_last, rsp_err}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("midrst_ready", req_ready, 1'b1);
        do_burst(32'h3000_0100, 3'd2, 1, 1, 1, 32'h1);

        for (int k = 0; k < 25; k++) begin
            l = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            a = (r == 0) ? $urandom_range(0, 32'h2fff_ffff) :
                (r == 1) ? 32'h4000_0000 + $urandom_range(0, 32'h0fff_ffff) :
                           32'h3000_0000 + $urandom_range(0, 32'h0fff_ffff);
            ea = ($urandom_range(0, 3) == 0) ?
                 beat_addr({a[31:2], 2'b00}, l, $urandom_range(0, int'(l))) : 32'h1;
            do_burst(a, l, $urandom_range(0, 3), $urandom_range(0, int'(l)), $urandom_range(0, 3), ea);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/flash_burst_rd.md
FLASH_BURST_RD -- requirements
Module: flash_burst_rd

Interface
REQ-001 SHALL have parameter FLASH_BASE, default 32'h30000000, lowest accepted byte address.
REQ-002 SHALL have parameter FLASH_END, default 32'h3fffffff, highest accepted byte address.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  burst read request valid.
REQ-006 SHALL have port req_ready  output  1  request accepted when both are high.
REQ-007 SHALL have port req_addr  input  P_ADDR_W  start byte address; bits [1:0] ignored.
REQ-008 SHALL have port req_len  input  3  beats minus one (1..8 words).
REQ-009 SHALL have port rsp_valid  output  1  response word valid.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when both are high.
REQ-011 SHALL have port rsp_data  output  P_DATA_W  read word.
REQ-012 SHALL have port rsp_last  output  1  final beat of burst.
REQ-013 SHALL have port rsp_err  output  1  beat carries an error.
REQ-014 SHALL have ports out_paddr/out_psel/out_penable/out_pwrite/out_pprot/out_pstrb/out_pwdata as outputs and out_pready/out_prdata/out_pslverr as inputs, APB master toward the SPI flash bridge.

Function
REQ-015 SHALL implement states IDLE, SETUP, ACCESS, RESP.
REQ-016 req_ready SHALL be high only in IDLE.
REQ-017 On acceptance SHALL latch word-aligned address and len, clear beat counter, go to SETUP the next cycle; with the address outside [FLASH_BASE, FLASH_END], SHALL instead go to RESP with rsp_err=1, rsp_last=1, rsp_data=0 and issue no APB transfer.
REQ-018 SETUP: out_psel=1, out_penable=0, for exactly one cycle, then ACCESS.
REQ-019 ACCESS: out_psel=1, out_penable=1; address/control held stable until out_pready=1.
REQ-020 On out_pready in ACCESS SHALL register out_prdata into rsp_data and out_pslverr into rsp_err, then enter RESP.
REQ-021 Minimum latency: request accepted at cycle N, psel at N+1, penable at N+2, rsp_valid at N+3 if pready at N+2.
REQ-022 RESP: rsp_valid=1, rsp_data/rsp_last/rsp_err held until rsp_ready; no APB transfer in flight.
REQ-023 On rsp_ready in RESP: if last beat SHALL go to IDLE, else increment counter, advance address by 4, go to SETUP.
REQ-024 rsp_last SHALL be 1 when beat counter equals len, or when rsp_err=1.
REQ-025 out_pslverr=1 SHALL terminate the burst: that beat is the last; remaining beats are not issued.
REQ-026 out_pwrite=0, out_pstrb=0, out_pwdata=0, out_pprot=3'b100 (instruction) constantly.
REQ-027 Address increment SHALL be modulo 2^P_ADDR_W; no range recheck mid-burst.

Reset
REQ-028 resetn low SHALL asynchronously force IDLE, req_ready=1 after release, out_psel=0, out_penable=0, out_paddr=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0.
REQ-029 Reset mid-burst SHALL drop the APB transfer immediately and discard all burst state.

Configuration
REQ-030 With FLASH_BURST_WRAP_EN defined, req_len of 1, 3 or 7 SHALL produce wrapping bursts: address increments within the (len+1)*4-byte aligned block, starting at the requested (critical) word; other lengths stay linear.
REQ-031 Without FLASH_BURST_WRAP_EN all bursts SHALL be linear.

Structure
REQ-032 State encodings and FLASH_BASE/FLASH_END defaults SHALL live in the shared amba define file alongside P_ADDR_W/P_DATA_W.
REQ-033 A sub-module flash_burst_addr_gen (linear/wrap next-address logic) SHALL be used; everything else stays flat.

Verification
REQ-034 req addr 0x30000010 len 0, pready at first ACCESS, prdata 0xDEADBEEF -> one rsp, data 0xDEADBEEF, last=1, err=0, rsp_valid 3 cycles after accept.
REQ-035 addr 0x30000000 len 3, slave 2 wait states per beat, rsp_ready stalled 4 cycles on beat 1 -> paddr 0x0,0x4,0x8,0xC sequence, no psel during stall, last on 4th beat.
REQ-036 addr 0x20000000 len 7 -> single rsp err=1 last=1 data 0, out_psel never asserted.
REQ-037 addr 0x30000000 len 7, pslverr on beat 2 -> 3 responses, third err=1 last=1, IDLE after.
REQ-038 With FLASH_BURST_WRAP_EN, addr 0x30000018 len 7 -> paddr 0x18,0x1C,0x00,0x04,0x08,0x0C,0x10,0x14 (offsets); without macro 0x18..0x34 linear.
REQ-039 resetn asserted during ACCESS of beat 1 -> psel/penable/rsp_valid low same cycle; new request after release completes normally.
